// File: rtl/my_mem_resp.sv
// my_mem_resp: parity-protected single-port memory responder, one-cycle read latency.
// Define MEM_PARITY_CHK_EN to add parity-flip injection and read-side parity checking.
module my_mem_resp #(
  parameter int ADDR_W = 16,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  output logic [8:0]        data_out,
  output logic              data_valid,
  output logic              unwritten_rd,
  output logic              conflict_err,
  output logic [ERR_W-1:0]  error_count
`ifdef MEM_PARITY_CHK_EN
  ,
  input  logic              inj_parity_flip,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    CONFL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [8:0]       mem [0:DEPTH-1];
  logic [DEPTH-1:0] written;
  logic             do_write;
  logic             do_read;
  logic             do_confl;
  logic [8:0]       rd_word;
  logic             rd_hit;
  logic             store_par;
  logic             par_bad;
  logic [1:0]       err_inc;

  function automatic logic par8(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] c,
                                               input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, c} + {{(ERR_W-1){1'b0}}, inc};
    if (sum[ERR_W]) begin
      return '1;
    end else begin
      return sum[ERR_W-1:0];
    end
  endfunction

  // Request decode and array lookup
  always_comb begin
    do_write = write & ~read;
    do_read  = read & ~write;
    do_confl = write & read;
    rd_word  = mem[address];
    rd_hit   = written[address];
  end

`ifdef MEM_PARITY_CHK_EN
  // Stored parity (optionally corrupted) and read-side parity check
  always_comb begin
    store_par = par8(data_in) ^ inj_parity_flip;
    par_bad   = do_read & rd_hit & (rd_word[8] != par8(rd_word[7:0]));
  end
`else
  // Stored parity without checking
  always_comb begin
    store_par = par8(data_in);
    par_bad   = 1'b0;
  end
`endif

  // Errors found at this edge, conflicts and parity faults counted separately
  always_comb begin
    err_inc = {1'b0, do_confl} + {1'b0, par_bad};
  end

  // Next state follows the sampled request pair every edge
  always_comb begin
    state_next = IDLE;
    case ({write, read})
      2'b01:   state_next = RESP;
      2'b11:   state_next = CONFL;
      default: state_next = IDLE;
    endcase
  end

  // Array write; contents survive reset, only the written flags are cleared
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[address] <= {store_par, data_in};
    end
  end

  // State, written flags and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      written      <= '0;
      data_out     <= 9'h000;
      unwritten_rd <= 1'b0;
      error_count  <= '0;
`ifdef MEM_PARITY_CHK_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      unwritten_rd <= do_read & ~rd_hit;
      error_count  <= sat_add(error_count, err_inc);
`ifdef MEM_PARITY_CHK_EN
      parity_err   <= par_bad;
`endif
      if (do_write) begin
        written[address] <= 1'b1;
      end
      // Never-written addresses answer zero rather than stale array contents
      if (do_read) begin
        data_out <= rd_hit ? rd_word : 9'h000;
      end
    end
  end

  assign data_valid   = (state == RESP);
  assign conflict_err = (state == CONFL);

endmodule
